// File: rtl/instruction_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bus bundle between the instruction fetch unit, instruction memory and the
// decode/control stage.
//   mem_req / mem_addr        : read request and word address (fetch unit drives)
//   mem_ack / mem_rdata       : read completion and data (memory drives)
//   inst_valid / inst / inst_pc : prefetch FIFO head (fetch unit drives)
//   inst_ready                : consumer takes the head this cycle
// Modports: master = fetch unit side, slave = memory + consumer side.
// -----------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
  parameter int ADDR_W = 30,
  parameter int INST_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [INST_W-1:0] mem_rdata;
  logic              inst_valid;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Generates sequential fetch addresses, reads instruction memory over a
// req/ack handshake (at most one request outstanding), buffers returned words
// in a prefetch FIFO and presents {inst, inst_pc} to the decode stage.
// Redirects flush the FIFO and restart fetching; a request that is in flight
// at redirect time is completed and its data discarded.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clk_enable      : global stall, low freezes every register (not reset)
//   redirect        : pulse, restart fetching at redirect_addr
//   redirect_addr   : new fetch word address
//   bus (master)    : memory request/response and FIFO head to consumer
//   fetch_pc        : next word address to be requested
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 30,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clk_enable,
  input  logic                       redirect,
  input  logic [ADDR_W-1:0]          redirect_addr,
  instruction_fetch_unit_if.master   bus,
  output logic [ADDR_W-1:0]          fetch_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t             state_r;
  logic               mem_req_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [ADDR_W-1:0]  fetch_pc_r;

  logic [INST_W-1:0]  inst_mem_r [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_r   [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic               ack_s;
  logic               pop_s;
  logic               push_s;
  logic [CNT_W-1:0]   occ_next_s;
  logic               space_s;

  // Handshake qualification and FIFO occupancy after this edge's push/pop.
  always_comb begin
    ack_s      = mem_req_r & bus.mem_ack;
    pop_s      = (count_r != {CNT_W{1'b0}}) & bus.inst_ready;
    // Only live (non-stale) data is pushed; a same-cycle redirect kills it.
    push_s     = (state_r == WAIT) & ack_s & ~redirect;
    occ_next_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    space_s    = (occ_next_s < CNT_W'(DEPTH));
  end

  // Fetch FSM: request issue, back-to-back streaming and stale-request drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= FETCH;
      mem_req_r  <= 1'b0;
      mem_addr_r <= RESET_PC;
      fetch_pc_r <= RESET_PC;
    end else if (clk_enable) begin
      if (redirect) begin
        fetch_pc_r <= redirect_addr;
        case (state_r)
          FETCH: begin
            state_r <= FETCH;
          end
          WAIT, DRAIN: begin
            // An acked request is finished (its data dropped); otherwise
            // keep it on the bus until the memory answers.
            if (ack_s) begin
              mem_req_r <= 1'b0;
              state_r   <= FETCH;
            end else begin
              state_r   <= DRAIN;
            end
          end
          default: begin
            mem_req_r <= 1'b0;
            state_r   <= FETCH;
          end
        endcase
      end else begin
        case (state_r)
          FETCH: begin
            if (space_s) begin
              mem_req_r  <= 1'b1;
              mem_addr_r <= fetch_pc_r;
              fetch_pc_r <= fetch_pc_r + ADDR_W'(1'b1);
              state_r    <= WAIT;
            end
          end
          WAIT: begin
            if (ack_s) begin
              if (space_s) begin
                mem_addr_r <= fetch_pc_r;
                fetch_pc_r <= fetch_pc_r + ADDR_W'(1'b1);
              end else begin
                mem_req_r <= 1'b0;
                state_r   <= FETCH;
              end
            end
          end
          DRAIN: begin
            if (ack_s) begin
              mem_req_r <= 1'b0;
              state_r   <= FETCH;
            end
          end
          default: begin
            mem_req_r <= 1'b0;
            state_r   <= FETCH;
          end
        endcase
      end
    end
  end

  // Prefetch FIFO pointers and occupancy; redirect flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clk_enable) begin
      if (redirect) begin
        rd_ptr_r <= {PTR_W{1'b0}};
        wr_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        end
        count_r <= occ_next_s;
      end
    end
  end

  // Prefetch FIFO storage (contents are don't-care while empty, so no reset).
  always_ff @(posedge clk) begin
    if (!rst && clk_enable && push_s) begin
      inst_mem_r[wr_ptr_r] <= bus.mem_rdata;
      pc_mem_r[wr_ptr_r]   <= bus.mem_addr;
    end
  end

  assign bus.mem_req    = mem_req_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.inst_valid = (count_r != {CNT_W{1'b0}});
  assign bus.inst       = inst_mem_r[rd_ptr_r];
  assign bus.inst_pc    = pc_mem_r[rd_ptr_r];
  assign fetch_pc       = fetch_pc_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit. DUT u_dut uses RESET_PC=0 with a
// memory model of programmable ack latency; DUT u_dut_wrap uses
// RESET_PC=3FFFFFFF with a zero-wait memory to exercise address wrap.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

  localparam int ADDR_W = 30;
  localparam int INST_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              clk_enable;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] fetch_pc;

  logic              rst2;
  logic              clk_enable2;
  logic              redirect2;
  logic [ADDR_W-1:0] redirect_addr2;
  logic [ADDR_W-1:0] fetch_pc2;

  int                lat       = 0;
  logic              force_ack = 1'b0;
  int                wait_cnt  = 0;

  int                tests = 0;
  int                fails = 0;

  instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus1 ();
  instruction_fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus2 ();

  instruction_fetch_unit #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(4), .RESET_PC(30'h0)
  ) u_dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .redirect(redirect),
    .redirect_addr(redirect_addr), .bus(bus1), .fetch_pc(fetch_pc)
  );

  instruction_fetch_unit #(
    .ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(4), .RESET_PC(30'h3FFFFFFF)
  ) u_dut_wrap (
    .clk(clk), .rst(rst2), .clk_enable(clk_enable2), .redirect(redirect2),
    .redirect_addr(redirect_addr2), .bus(bus2), .fetch_pc(fetch_pc2)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] pc);
    return {2'b11, pc} ^ 32'hA5A5_0F0F;
  endfunction

  // Memory model: ack after 'lat' extra cycles of a held request.
  assign bus1.mem_ack   = force_ack | (bus1.mem_req && (wait_cnt >= lat));
  assign bus1.mem_rdata = inst_of(bus1.mem_addr);
  always @(posedge clk) begin
    if (!bus1.mem_req || bus1.mem_ack) wait_cnt <= 0;
    else                               wait_cnt <= wait_cnt + 1;
  end

  assign bus2.mem_ack   = bus2.mem_req;
  assign bus2.mem_rdata = inst_of(bus2.mem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; clk_enable = 1'b1; redirect = 1'b0; redirect_addr = 30'h0;
    bus1.inst_ready = 1'b1;
    rst2 = 1'b1; clk_enable2 = 1'b1; redirect2 = 1'b0; redirect_addr2 = 30'h0;
    bus2.inst_ready = 1'b1;
    tick(); tick();

    // Reset state
    check("rst_mem_req",    bus1.mem_req,    1'b0);
    check("rst_mem_addr",   bus1.mem_addr,   30'h0);
    check("rst_fetch_pc",   fetch_pc,        30'h0);
    check("rst_inst_valid", bus1.inst_valid, 1'b0);

    // T1: zero-wait streaming
    rst = 1'b0;
    tick();
    check("t1_req_rise",  bus1.mem_req,    1'b1);
    check("t1_req_addr0", bus1.mem_addr,   30'h0);
    check("t1_valid_lo",  bus1.inst_valid, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("t1_valid",    bus1.inst_valid, 1'b1);
      check("t1_inst_pc",  bus1.inst_pc,    30'(i));
      check("t1_inst",     bus1.inst,       inst_of(30'(i)));
      check("t1_mem_addr", bus1.mem_addr,   30'(i + 1));
    end

    // T2: consumer stalls, FIFO fills, then drains in order
    rst = 1'b1; bus1.inst_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("t2_full_req",   bus1.mem_req,    1'b0);
    check("t2_full_valid", bus1.inst_valid, 1'b1);
    check("t2_full_head",  bus1.inst_pc,    30'h0);
    check("t2_full_fpc",   fetch_pc,        30'h4);
    force_ack = 1'b1;  // ack without request must be ignored
    tick(); tick();
    force_ack = 1'b0;
    check("t2_stray_ack_req", bus1.mem_req, 1'b0);
    check("t2_stray_ack_fpc", fetch_pc,     30'h4);
    bus1.inst_ready = 1'b1;
    tick();
    check("t2_resume_head", bus1.inst_pc,  30'h1);
    check("t2_resume_req",  bus1.mem_req,  1'b1);
    check("t2_resume_addr", bus1.mem_addr, 30'h4);
    for (int j = 2; j < 8; j++) begin
      tick();
      check("t2_drain_pc",   bus1.inst_pc, 30'(j));
      check("t2_drain_inst", bus1.inst,    inst_of(30'(j)));
    end

    // Reset while a request is outstanding, with a late ack
    lat = 3; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("rmr_req",  bus1.mem_req,  1'b1);
    check("rmr_addr", bus1.mem_addr, 30'h0);
    rst = 1'b1; force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    check("rmr_req_drop", bus1.mem_req,    1'b0);
    check("rmr_valid",    bus1.inst_valid, 1'b0);
    check("rmr_fpc",      fetch_pc,        30'h0);

    // T3: redirect while a slow request to 0x5 is outstanding
    rst = 1'b0; redirect = 1'b1; redirect_addr = 30'h5;
    tick();
    check("t3_idle_redir_fpc", fetch_pc,     30'h5);
    check("t3_idle_redir_req", bus1.mem_req, 1'b0);
    redirect = 1'b0;
    tick();
    check("t3_req5",      bus1.mem_req,  1'b1);
    check("t3_req5_addr", bus1.mem_addr, 30'h5);
    redirect = 1'b1; redirect_addr = 30'h100;
    tick();
    redirect = 1'b0;
    check("t3_drain_req",   bus1.mem_req,    1'b1);
    check("t3_drain_addr",  bus1.mem_addr,   30'h5);
    check("t3_drain_fpc",   fetch_pc,        30'h100);
    check("t3_drain_valid", bus1.inst_valid, 1'b0);
    tick(); tick();
    check("t3_hold_addr", bus1.mem_addr, 30'h5);
    tick();
    check("t3_drop_req",   bus1.mem_req,    1'b0);
    check("t3_drop_valid", bus1.inst_valid, 1'b0);
    tick();
    check("t3_new_req",  bus1.mem_req,  1'b1);
    check("t3_new_addr", bus1.mem_addr, 30'h100);
    for (int k = 0; k < 20 && !bus1.inst_valid; k++) tick();
    check("t3_first_valid", bus1.inst_valid, 1'b1);
    check("t3_first_pc",    bus1.inst_pc,    30'h100);
    check("t3_first_inst",  bus1.inst,       inst_of(30'h100));

    // T4: redirect in the same cycle as an ack, then with a busy FIFO
    lat = 0; rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    redirect = 1'b1; redirect_addr = 30'h40;
    tick();
    redirect = 1'b0;
    check("t4_req_drop", bus1.mem_req,    1'b0);
    check("t4_valid_lo", bus1.inst_valid, 1'b0);
    check("t4_fpc",      fetch_pc,        30'h40);
    tick();
    check("t4_req40",    bus1.mem_addr,   30'h40);
    check("t4_valid_lo2", bus1.inst_valid, 1'b0);
    tick();
    check("t4_first_pc",   bus1.inst_pc, 30'h40);
    check("t4_first_inst", bus1.inst,    inst_of(30'h40));
    tick(); tick();
    check("t4_head42", bus1.inst_pc,  30'h42);
    check("t4_addr43", bus1.mem_addr, 30'h43);
    redirect = 1'b1; redirect_addr = 30'h80;
    tick();
    redirect = 1'b0;
    check("t4_flush_valid", bus1.inst_valid, 1'b0);
    check("t4_flush_req",   bus1.mem_req,    1'b0);
    check("t4_flush_fpc",   fetch_pc,        30'h80);
    tick();
    check("t4_req80", bus1.mem_addr, 30'h80);
    tick();
    check("t4_pc80", bus1.inst_pc, 30'h80);

    // T6: global stall mid-stream while ack is asserted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("t6_pre_pc",   bus1.inst_pc,  30'h3);
    check("t6_pre_addr", bus1.mem_addr, 30'h4);
    clk_enable = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("t6_frz_pc",    bus1.inst_pc,    30'h3);
      check("t6_frz_addr",  bus1.mem_addr,   30'h4);
      check("t6_frz_fpc",   fetch_pc,        30'h5);
      check("t6_frz_valid", bus1.inst_valid, 1'b1);
    end
    clk_enable = 1'b1;
    for (int i = 4; i < 9; i++) begin
      tick();
      check("t6_post_pc",    bus1.inst_pc,    30'(i));
      check("t6_post_valid", bus1.inst_valid, 1'b1);
    end

    // T5: wrap from 3FFFFFFF to 0
    check("t5_rst_addr", bus2.mem_addr, 30'h3FFFFFFF);
    check("t5_rst_fpc",  fetch_pc2,     30'h3FFFFFFF);
    rst2 = 1'b0;
    tick();
    check("t5_req_top", bus2.mem_addr, 30'h3FFFFFFF);
    check("t5_fpc0",    fetch_pc2,     30'h0);
    tick();
    check("t5_req0",   bus2.mem_addr, 30'h0);
    check("t5_pc_top", bus2.inst_pc,  30'h3FFFFFFF);
    tick();
    check("t5_pc0",  bus2.inst_pc,  30'h0);
    check("t5_req1", bus2.mem_addr, 30'h1);
    tick();
    check("t5_pc1",   bus2.inst_pc, 30'h1);
    check("t5_inst1", bus2.inst,    inst_of(30'h1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
